// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_pkg
// Description : Shared types, byte constants, error bit positions and the
//               CRC7 helper for the SD-over-SPI command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_R1    = 3'd2,
        ST_EXTRA = 3'd3,
        ST_TOKEN = 3'd4,
        ST_DATA  = 3'd5,
        ST_CRC   = 3'd6,
        ST_FIN   = 3'd7
    } sd_state_e;

    localparam logic [7:0]  START_TOKEN = 8'hFE;
    localparam logic [7:0]  IDLE_BYTE   = 8'hFF;
    localparam logic [1:0]  CMD_PREFIX  = 2'b01;

    localparam int ERR_R1_TIMEOUT    = 0;
    localparam int ERR_TOKEN_TIMEOUT = 1;
    localparam int ERR_CRC           = 2;

    localparam logic [6:0]  CRC7_POLY   = 7'h09;
    localparam logic [15:0] CRC16_POLY  = 16'h1021;

    // Advances the CRC7 by one command byte, MSB first.
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] din);
        logic [6:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ din[i];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ CRC7_POLY;
            end
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_crc16.sv
`default_nettype none
// ============================================================================
// Module      : sd_crc16
// Description : Byte-wide parallel CRC16-CCITT (init 0) with clear and enable.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_crc16
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;
    logic        fb;

    always_comb begin
        crc_d = crc_q;
        fb    = 1'b0;
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            for (int i = 7; i >= 0; i--) begin
                fb    = crc_d[15] ^ din[i];
                crc_d = {crc_d[14:0], 1'b0};
                if (fb) begin
                    crc_d = crc_d ^ CRC16_POLY;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/sd_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : sd_cmd_seq
// Description : SD-over-SPI command sequencer: frame + CRC7, R1 poll, trailing
//               response bytes, data token wait and block read with backpressure.
//               Define SD_DATA_CRC_EN to check the block CRC16.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_cmd_seq
    import sd_pkg::*;
#(
    parameter logic [15:0] NCR_MAX   = 16'd8,
    parameter logic [15:0] TOKEN_MAX = 16'd50000,
    parameter logic [15:0] BLOCK_LEN = 16'd512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [2:0]  resp_extra,
    input  logic        read_block,
    output logic        xfer_req,
    output logic [7:0]  xfer_tx,
    input  logic        xfer_done,
    input  logic [7:0]  xfer_rx,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        busy,
    output logic        done,
    output logic [7:0]  r1,
    output logic [31:0] resp,
    output logic [2:0]  err
);

    sd_state_e   state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic [2:0]  extra_q, extra_d;
    logic        rdblk_q, rdblk_d;
    logic [15:0] cnt_q, cnt_d;
    logic [6:0]  crc7_q, crc7_d;
    logic [7:0]  r1_q, r1_d;
    logic [31:0] resp_q, resp_d;
    logic [2:0]  err_q, err_d;
    logic [7:0]  data_q, data_d;
    logic        data_valid_q, data_valid_d;

    logic [15:0] cnt_inc;
    logic        xfer_fire;
    logic        data_fire;
    logic        crc_bad;
    logic [7:0]  cmd_byte;

    // A data byte must be drained before the next exchange is requested.
    assign xfer_req  = (state_q == ST_CMD) || (state_q == ST_R1) || (state_q == ST_EXTRA) ||
                       (state_q == ST_TOKEN) || (state_q == ST_CRC) ||
                       ((state_q == ST_DATA) && !data_valid_q);
    assign xfer_fire = xfer_req && xfer_done;
    assign data_fire = data_valid_q && data_ready;
    assign cnt_inc   = cnt_q + 16'd1;

    always_comb begin
        case (cnt_q[2:0])
            3'd0:    cmd_byte = {CMD_PREFIX, idx_q};
            3'd1:    cmd_byte = arg_q[31:24];
            3'd2:    cmd_byte = arg_q[23:16];
            3'd3:    cmd_byte = arg_q[15:8];
            3'd4:    cmd_byte = arg_q[7:0];
            3'd5:    cmd_byte = {crc7_q, 1'b1};
            default: cmd_byte = IDLE_BYTE;
        endcase
    end

    assign xfer_tx = (state_q == ST_CMD) ? cmd_byte : IDLE_BYTE;

`ifdef SD_DATA_CRC_EN
    logic [15:0] crc16;
    logic [7:0]  crc_hi_q, crc_hi_d;

    sd_crc16 u_crc16 (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == ST_IDLE),
        .en    (data_fire),
        .din   (data_q),
        .crc   (crc16)
    );

    assign crc_hi_d = ((state_q == ST_CRC) && xfer_fire && (cnt_q == 16'd0)) ? xfer_rx : crc_hi_q;
    assign crc_bad  = ({crc_hi_q, xfer_rx} != crc16);

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_hi_q <= '0;
        end else begin
            crc_hi_q <= crc_hi_d;
        end
    end
`else
    assign crc_bad = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        arg_d        = arg_q;
        extra_d      = extra_q;
        rdblk_d      = rdblk_q;
        cnt_d        = cnt_q;
        crc7_d       = crc7_q;
        r1_d         = r1_q;
        resp_d       = resp_q;
        err_d        = err_q;
        data_d       = data_q;
        data_valid_d = data_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = cmd_index;
                    arg_d   = cmd_arg;
                    extra_d = (resp_extra > 3'd4) ? 3'd4 : resp_extra;
                    rdblk_d = read_block;
                    err_d   = '0;
                    resp_d  = '0;
                    cnt_d   = '0;
                    crc7_d  = '0;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (xfer_fire) begin
                    if (cnt_q == 16'd5) begin
                        cnt_d   = '0;
                        state_d = ST_R1;
                    end else begin
                        crc7_d = crc7_byte(crc7_q, cmd_byte);
                        cnt_d  = cnt_inc;
                    end
                end
            end
            ST_R1: begin
                if (xfer_fire) begin
                    if (!xfer_rx[7]) begin
                        r1_d  = xfer_rx;
                        cnt_d = '0;
                        if (extra_q != 3'd0) begin
                            state_d = ST_EXTRA;
                        end else if (rdblk_q && (xfer_rx == 8'h00)) begin
                            state_d = ST_TOKEN;
                        end else begin
                            state_d = ST_FIN;
                        end
                    end else if (cnt_inc == NCR_MAX) begin
                        err_d[ERR_R1_TIMEOUT] = 1'b1;
                        state_d               = ST_FIN;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_EXTRA: begin
                if (xfer_fire) begin
                    resp_d = {resp_q[23:0], xfer_rx};
                    if (cnt_inc == {13'd0, extra_q}) begin
                        cnt_d   = '0;
                        state_d = (rdblk_q && (r1_q == 8'h00)) ? ST_TOKEN : ST_FIN;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_TOKEN: begin
                if (xfer_fire) begin
                    if (xfer_rx == START_TOKEN) begin
                        cnt_d   = '0;
                        state_d = ST_DATA;
                    end else if ((xfer_rx != IDLE_BYTE) || (cnt_inc == TOKEN_MAX)) begin
                        err_d[ERR_TOKEN_TIMEOUT] = 1'b1;
                        state_d                  = ST_FIN;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_DATA: begin
                if (xfer_fire) begin
                    data_d       = xfer_rx;
                    data_valid_d = 1'b1;
                    cnt_d        = cnt_inc;
                end
                if (data_fire) begin
                    data_valid_d = 1'b0;
                    if (cnt_q == BLOCK_LEN) begin
                        cnt_d   = '0;
                        state_d = ST_CRC;
                    end
                end
            end
            ST_CRC: begin
                if (xfer_fire) begin
                    if (cnt_q == 16'd1) begin
                        if (crc_bad) begin
                            err_d[ERR_CRC] = 1'b1;
                        end
                        cnt_d   = '0;
                        state_d = ST_FIN;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            arg_q        <= '0;
            extra_q      <= '0;
            rdblk_q      <= 1'b0;
            cnt_q        <= '0;
            crc7_q       <= '0;
            r1_q         <= 8'hFF;
            resp_q       <= '0;
            err_q        <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            arg_q        <= arg_d;
            extra_q      <= extra_d;
            rdblk_q      <= rdblk_d;
            cnt_q        <= cnt_d;
            crc7_q       <= crc7_d;
            r1_q         <= r1_d;
            resp_q       <= resp_d;
            err_q        <= err_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign busy       = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done       = (state_q == ST_FIN);
    assign r1         = r1_q;
    assign resp       = resp_q;
    assign err        = err_q;
    assign data_out   = data_q;
    assign data_valid = data_valid_q;

endmodule
`default_nettype wire
